// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the CPU, host and memory-side signals of the two-port
//          memory arbiter.
// Ports  : cpu_*  - CPU request/grant/read-return channel
//          host_* - debug/loader host channel, plus host_lock
//          mem_*  - single memory port (address, write data, write enable, read data)
// Modports: slave  - the arbiter side
//           master - the requester/memory side (testbench or surrounding logic)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned DATA_W = 16;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_lock;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        input  mem_q,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_data, mem_wren
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        output mem_q,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one memory port between a CPU and a debug/loader host.
//          CPU has priority; the host is forced through after STARVE_LIMIT
//          consecutive CPU grants, and can hold the port with host_lock.
//          Grants and the memory bus are combinational; read data returns
//          one cycle after the grant with a one-cycle rvalid pulse.
// Ports  : clock  - system clock (posedge)
//          reset  - synchronous, active-high reset
//          bus    - mem_arbiter_if.slave (CPU, host and memory channels)
//          owner  - debug view of the FSM state: 00 IDLE, 01 CPU, 10 HOST, 11 LOCK
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   owner
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_HOST = 2'b10,
        ST_LOCK = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               cpu_rd_q, cpu_rd_d;
    logic               host_rd_q, host_rd_d;
    logic [DATA_W-1:0]  cpu_rdata_q, host_rdata_q;

    logic               cpu_gnt_c, host_gnt_c;
    logic               lock_hold_c, starved_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [DATA_W-1:0]  mem_data_c;
    logic               mem_wren_c;
    logic [DATA_W-1:0]  cpu_rdata_c, host_rdata_c;

    // State, starvation counter, read-return pipeline and held read data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            cpu_rd_q     <= 1'b0;
            host_rd_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            cpu_rd_q     <= cpu_rd_d;
            host_rd_q    <= host_rd_d;
            cpu_rdata_q  <= cpu_rdata_c;
            host_rdata_q <= host_rdata_c;
        end
    end

    // Grant decision, memory bus steering and next-state logic
    always_comb begin
        state_d     = ST_IDLE;
        starve_d    = starve_q;
        cpu_gnt_c   = 1'b0;
        host_gnt_c  = 1'b0;
        mem_addr_c  = ADDR_W'(0);
        mem_data_c  = '0;
        mem_wren_c  = 1'b0;
        cpu_rd_d    = 1'b0;
        host_rd_d   = 1'b0;

        // LOCK only keeps priority while host_lock stays high; once it drops
        // the normal CPU-first priority applies in that same cycle.
        lock_hold_c = (state_q == ST_LOCK) && bus.host_lock;
        starved_c   = (starve_q == CNT_W'(STARVE_LIMIT));

        if (!reset) begin
            host_gnt_c = bus.host_req && (!bus.cpu_req || starved_c || lock_hold_c);
            cpu_gnt_c  = bus.cpu_req && !host_gnt_c;
        end

        if (cpu_gnt_c) begin
            mem_addr_c = bus.cpu_addr;
            mem_data_c = bus.cpu_wdata;
            mem_wren_c = bus.cpu_we;
            cpu_rd_d   = !bus.cpu_we;
            state_d    = ST_CPU;
        end else if (host_gnt_c) begin
            mem_addr_c = bus.host_addr;
            mem_data_c = bus.host_wdata;
            mem_wren_c = bus.host_we;
            host_rd_d  = !bus.host_we;
            state_d    = bus.host_lock ? ST_LOCK : ST_HOST;
        end else if (state_q == ST_LOCK) begin
            // Idle lock: hold while locked, else fall back to the host as last owner
            state_d    = bus.host_lock ? ST_LOCK : ST_HOST;
        end

        if (!bus.host_req || host_gnt_c) begin
            starve_d = '0;
        end else if (cpu_gnt_c && !starved_c) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Read data is captured from mem_q in the return cycle and held afterwards;
    // reset masks the return pipeline immediately.
    always_comb begin
        cpu_rdata_c  = cpu_rdata_q;
        host_rdata_c = host_rdata_q;
        if (reset) begin
            cpu_rdata_c  = '0;
            host_rdata_c = '0;
        end else begin
            if (cpu_rd_q)  cpu_rdata_c  = bus.mem_q;
            if (host_rd_q) host_rdata_c = bus.mem_q;
        end
    end

    assign bus.cpu_gnt     = cpu_gnt_c;
    assign bus.host_gnt    = host_gnt_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_data    = mem_data_c;
    assign bus.mem_wren    = mem_wren_c;
    assign bus.cpu_rvalid  = cpu_rd_q && !reset;
    assign bus.host_rvalid = host_rd_q && !reset;
    assign bus.cpu_rdata   = cpu_rdata_c;
    assign bus.host_rdata  = host_rdata_c;
    assign owner           = reset ? 2'(ST_IDLE) : 2'(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter. Directed stimulus pushes the
//          expected grant and read-return records into queues; a negedge
//          monitor pops and compares whenever the DUT presents a grant or
//          rvalid, and flags missing or unexpected responses.
module tb_mem_arbiter;
    logic       clock;
    logic       reset;
    logic [1:0] owner;
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    typedef struct {
        logic        who;   // 0 = CPU, 1 = host
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } gnt_t;

    typedef struct {
        logic        who;
        logic [15:0] data;
        int          due;
    } rv_t;

    gnt_t gq[$];
    rv_t  rq[$];
    logic [15:0] mem [256];

    mem_arbiter_if #(.ADDR_W(16)) bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .owner (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: registered read, data valid one cycle after the address
    always @(posedge clock) begin
        if (reset) begin
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'hCAFE;
            mem[8'h05] <= 16'h5A5A;
            mem[8'h03] <= 16'h0000;
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_addr[7:0]];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares grants and read returns against the scoreboard
    always @(negedge clock) begin
        gnt_t g;
        rv_t  r;
        checks++;
        if (bus.cpu_gnt && bus.host_gnt) begin
            errors++;
            $display("FAIL gnt_excl: both grants high at cycle %0d", cyc);
        end else if (bus.cpu_gnt || bus.host_gnt) begin
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL gnt_unexp: got %s grant, expected none (cycle %0d)",
                         bus.host_gnt ? "host" : "cpu", cyc);
            end else begin
                g = gq.pop_front();
                if (g.who != bus.host_gnt || g.addr != bus.mem_addr ||
                    g.data != bus.mem_data || g.we != bus.mem_wren) begin
                    errors++;
                    $display("FAIL gnt: got who=%0d addr=%h data=%h we=%0d expected who=%0d addr=%h data=%h we=%0d (cycle %0d)",
                             bus.host_gnt, bus.mem_addr, bus.mem_data, bus.mem_wren,
                             g.who, g.addr, g.data, g.we, cyc);
                end
            end
        end else if (gq.size() != 0) begin
            g = gq.pop_front();
            errors++;
            $display("FAIL gnt_missing: got no grant, expected who=%0d addr=%h (cycle %0d)",
                     g.who, g.addr, cyc);
        end else if (bus.mem_wren || bus.mem_addr != 16'h0 || bus.mem_data != 16'h0) begin
            errors++;
            $display("FAIL idle_bus: got addr=%h data=%h we=%0d expected all 0 (cycle %0d)",
                     bus.mem_addr, bus.mem_data, bus.mem_wren, cyc);
        end

        if (bus.cpu_rvalid || bus.host_rvalid) begin
            checks++;
            if (bus.cpu_rvalid && bus.host_rvalid) begin
                errors++;
                $display("FAIL rv_excl: both rvalid high at cycle %0d", cyc);
            end else if (rq.size() == 0) begin
                errors++;
                $display("FAIL rv_unexp: got %s rvalid, expected none (cycle %0d)",
                         bus.host_rvalid ? "host" : "cpu", cyc);
            end else begin
                r = rq.pop_front();
                if (r.who != bus.host_rvalid || r.due != cyc ||
                    r.data != (bus.host_rvalid ? bus.host_rdata : bus.cpu_rdata)) begin
                    errors++;
                    $display("FAIL rv: got who=%0d data=%h cycle=%0d expected who=%0d data=%h cycle=%0d",
                             bus.host_rvalid, bus.host_rvalid ? bus.host_rdata : bus.cpu_rdata,
                             cyc, r.who, r.data, r.due);
                end
            end
        end else if (rq.size() != 0 && rq[0].due <= cyc) begin
            checks++;
            errors++;
            r = rq.pop_front();
            $display("FAIL rv_missing: got no rvalid, expected who=%0d data=%h (cycle %0d)",
                     r.who, r.data, cyc);
        end
    end

    // One cycle of stimulus. exp_g: 0 none, 1 CPU, 2 host. A read grant with
    // rv=1 expects its rvalid next cycle carrying exp_rd.
    task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                        input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
                        input logic hl, input int exp_g, input logic rv, input logic [15:0] exp_rd);
        gnt_t g;
        rv_t  r;
        bus.cpu_req   = cr;  bus.cpu_we   = cw;  bus.cpu_addr  = ca;  bus.cpu_wdata  = cd;
        bus.host_req  = hr;  bus.host_we  = hw;  bus.host_addr = ha;  bus.host_wdata = hd;
        bus.host_lock = hl;
        if (exp_g == 1) begin
            g = '{who: 1'b0, we: cw, addr: ca, data: cd};
            gq.push_back(g);
            if (!cw && rv) begin
                r = '{who: 1'b0, data: exp_rd, due: cyc + 1};
                rq.push_back(r);
            end
        end else if (exp_g == 2) begin
            g = '{who: 1'b1, we: hw, addr: ha, data: hd};
            gq.push_back(g);
            if (!hw && rv) begin
                r = '{who: 1'b1, data: exp_rd, due: cyc + 1};
                rq.push_back(r);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_lock = 0;
        repeat (2) @(posedge clock);
        #1;
        // Requests during reset must not be granted
        bus.cpu_req = 1; bus.host_req = 1; bus.cpu_we = 1; bus.host_we = 1;
        #1;
        chk("rst_owner", owner, 0);
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_host_gnt", bus.host_gnt, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // CPU-only read, granted in the first cycle after reset
        step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 1, 16'hBEEF);
        chk("cpu_read_owner", owner, 1);
        idle();
        idle();
        chk("cpu_rdata_hold", bus.cpu_rdata, 16'hBEEF);
        chk("idle_owner", owner, 0);

        // Host write with CPU idle: no rvalid afterwards
        step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0003, 16'h1234, 0, 2, 0, 16'h0);
        chk("host_wr_owner", owner, 2);
        idle();

        // Starvation: C,C,C,C,H repeating while both request continuously
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0003, 16'h0, 0, 2, 1, 16'h1234);
            else
                step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0003, 16'h0, 0, 1, 1, 16'hBEEF);
            chk("starve_owner", owner, (i % 5 == 4) ? 2 : 1);
        end
        idle();

        // Lock: host takes the port, then keeps it against a requesting CPU
        step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h7777, 1, 2, 0, 16'h0);
        chk("lock_owner0", owner, 3);
        step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0040, 16'h0, 1, 2, 1, 16'h7777);
        chk("lock_owner1", owner, 3);
        step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0003, 16'h0, 1, 2, 1, 16'h1234);
        chk("lock_owner2", owner, 3);
        step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0005, 16'h0, 1, 2, 1, 16'h5A5A);
        chk("lock_owner3", owner, 3);
        chk("host_rdata_hold", bus.host_rdata, 16'h5A5A);
        // host_lock drops: CPU wins that same cycle
        step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0005, 16'h0, 0, 1, 1, 16'hBEEF);
        chk("unlock_owner", owner, 1);
        // Host withdraws its request before being granted
        idle();
        idle();

        // Interleave: CPU read then host write back to back
        step(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 1, 16'hCAFE);
        step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0008, 16'hABCD, 0, 2, 0, 16'h0);
        idle();
        chk("interleave_rdata", bus.cpu_rdata, 16'hCAFE);
        chk("interleave_host_rdata", bus.host_rdata, 16'h5A5A);

        // Withdrawn host request while CPU is granted
        step(1, 1, 16'h0009, 16'h1111, 1, 1, 16'h0009, 16'h2222, 0, 1, 0, 16'h0);
        idle();

        // Reset mid-read: no rvalid, owner and rdata cleared in the reset cycle
        step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
        bus.cpu_req = 0;
        reset = 1'b1;
        #1;
        chk("midrst_rvalid", bus.cpu_rvalid, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_rdata", bus.cpu_rdata, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 1, 16'hCAFE);
        chk("post_rst_owner", owner, 1);
        idle();
        idle();

        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
